// File: rtl/cpu_mem_pkg.sv
// Shared request type, FSM states and width localparams for the main-memory model.
// Widths mirror the CPU_define.vh values: 64-bit lines, 8-bit bytes, 32-bit physical addresses.
package cpu_mem_pkg;

  localparam int BYTE_WIDTH          = 8;
  localparam int PHYSICAL_ADDR_WIDTH = 32;
  localparam int LINE_WIDTH          = 64;
  localparam int MEM_ADDR_WIDTH      = PHYSICAL_ADDR_WIDTH - $clog2(LINE_WIDTH / BYTE_WIDTH);

  typedef struct packed {
    logic                      write;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0]     data;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } mem_state_t;

endpackage

// File: rtl/cpu_mem_req_fifo.sv
// In-order request queue for the main-memory model; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
module cpu_mem_req_fifo
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  mem_req_t i_data,
  input  logic     i_pop,
  output mem_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  mem_req_t    r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
  // Same index with differing wrap bits means the writer has lapped the reader.
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/cpu_main_memory.sv
// Line-granular main memory: queued requests serviced one at a time after LATENCY cycles,
// reads answered with a one-cycle response pulse. Define CPU_MEM_WRITE_ACK_EN to acknowledge writes too.
module cpu_main_memory
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 4,
  parameter int REQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0]     req_data,
  output logic                      resp_valid,
  output logic [LINE_WIDTH-1:0]     resp_data,
  output logic [MEM_ADDR_WIDTH-1:0] resp_addr
);

  localparam int               IDX_W    = $clog2(MEM_LINES);
  localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t                r_state;
  mem_state_t                w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  mem_req_t                  r_req;
  mem_req_t                  w_req_in;
  mem_req_t                  w_fifo_head;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_access;
  logic                      w_respond;
  logic [IDX_W-1:0]          w_idx;
  logic                      r_resp_valid;
  logic [LINE_WIDTH-1:0]     r_resp_data;
  logic [MEM_ADDR_WIDTH-1:0] r_resp_addr;
  logic [LINE_WIDTH-1:0]     r_mem [MEM_LINES];

  assign w_req_in  = {req_write, req_addr, req_data};
  assign req_ready = !w_full;

  cpu_mem_req_fifo #(
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (req_valid && req_ready),
    .i_data  (w_req_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Upper address bits are dropped here, so addresses alias modulo MEM_LINES.
  assign w_idx = r_req.addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_access    = 1'b0;
    w_respond   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_access    = 1'b1;
`ifdef CPU_MEM_WRITE_ACK_EN
          w_respond   = 1'b1;
`else
          w_respond   = !r_req.write;
`endif
          w_state_nxt = w_respond ? RESPOND : IDLE;
        end
      end
      RESPOND: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_req <= w_fifo_head;
  end

  always_ff @(posedge clk) begin
    if (w_access && r_req.write) r_mem[w_idx] <= r_req.data;
  end

  // Response valid is registered from the next-state decode so it is a clean one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_addr  <= '0;
    end else begin
      r_resp_valid <= (w_state_nxt == RESPOND);
      if (w_respond) begin
        r_resp_addr <= r_req.addr;
        r_resp_data <= r_req.write ? r_req.data : r_mem[w_idx];
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_addr  = r_resp_addr;

endmodule

// File: tb/tb_cpu_main_memory.sv
// Scoreboard bench for cpu_main_memory: directed requests push expected responses,
// a negedge monitor pops and compares every response pulse.
`timescale 1ns/1ps
module tb_cpu_main_memory;
  import cpu_mem_pkg::*;

  localparam int LAT = 4;

  typedef struct {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0]     data;
    int                        at_edge;
    int                        gap;
  } exp_t;

  logic                      clk;
  logic                      reset;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [MEM_ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0]     req_data;
  logic                      resp_valid;
  logic [LINE_WIDTH-1:0]     resp_data;
  logic [MEM_ADDR_WIDTH-1:0] resp_addr;

  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   acc_edge = 0;
  int   n_resp = 0;
  int   last_resp_edge = 0;
  logic prev_v = 1'b0;
  exp_t exp_q[$];

  localparam logic [LINE_WIDTH-1:0] D_A5  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [LINE_WIDTH-1:0] D_03  = 64'h0303_0303_C0DE_0003;
  localparam logic [LINE_WIDTH-1:0] D_105 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [LINE_WIDTH-1:0] D_30  = 64'hDEAD_BEEF_0000_0030;
  localparam logic [LINE_WIDTH-1:0] D_40Y = 64'h4040_4040_4040_4040;
  localparam logic [LINE_WIDTH-1:0] D_40Z = 64'hFFFF_0000_FFFF_0000;
  localparam logic [LINE_WIDTH-1:0] D_50  = 64'h5050_0000_0000_0050;

  cpu_main_memory #(
    .MEM_LINES (256),
    .LATENCY   (LAT),
    .REQ_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      n_resp++;
      chk("pulse_width", 64'(prev_v), 64'(0));
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got addr=%h data=%h want no response", resp_addr, resp_data);
      end else begin
        e = exp_q.pop_front();
        chk("resp_addr", 64'(resp_addr), 64'(e.addr));
        chk("resp_data", resp_data, e.data);
        if (e.at_edge >= 0) chk("resp_latency", 64'(edge_n), 64'(e.at_edge));
        if (e.gap > 0) chk("resp_spacing", 64'(edge_n - last_resp_edge), 64'(e.gap));
      end
      last_resp_edge = edge_n;
    end
    prev_v = resp_valid;
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic w, input int a, input logic [LINE_WIDTH-1:0] d);
    int waits;
    waits = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a[MEM_ADDR_WIDTH-1:0];
    req_data  = d;
    while (!req_ready && waits < 200) begin
      @(posedge clk);
      #1;
      waits++;
    end
    chk("accept_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    acc_edge  = edge_n;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  // Every write in this bench is issued into an idle, empty block, so an ack is timed exactly.
  task automatic wr(input int a, input logic [LINE_WIDTH-1:0] d);
    exp_t e;
    issue(1'b1, a, d);
    e.addr    = a[MEM_ADDR_WIDTH-1:0];
    e.data    = d;
    e.at_edge = acc_edge + LAT + 1;
    e.gap     = 0;
`ifdef CPU_MEM_WRITE_ACK_EN
    exp_q.push_back(e);
`endif
  endtask

  task automatic rd(input int a, input logic [LINE_WIDTH-1:0] exp_d, input logic timed, input int gap);
    exp_t e;
    issue(1'b0, a, '0);
    e.addr    = a[MEM_ADDR_WIDTH-1:0];
    e.data    = exp_d;
    e.at_edge = timed ? acc_edge + LAT + 1 : -1;
    e.gap     = gap;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (8 * (LAT + 2)) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int exp_n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", resp_data, 64'(0));
    chk("rst_resp_addr", 64'(resp_addr), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Write then read the same line: read must return the new data.
    wr('h10, D_A5);
    rd('h10, D_A5, 1'b0, 0);
    drain();

    // Single read into an idle, empty block: exact latency.
    wr('h3, D_03);
    drain();
    rd('h3, D_03, 1'b1, 0);
    drain();

    // 0x105 aliases onto line 0x005 with 256 lines.
    wr('h105, D_105);
    rd('h005, D_105, 1'b0, 0);
    drain();

    // Stall the FSM on a write, then queue five reads; the 4th fills the FIFO.
    wr('h30, D_30);
    rd('h10, D_A5, 1'b0, 0);
    rd('h3, D_03, 1'b0, LAT + 2);
    rd('h5, D_105, 1'b0, LAT + 2);
    chk("ready_before_full", 64'(req_ready), 64'(1));
    rd('h30, D_30, 1'b0, LAT + 2);
    chk("ready_after_4th", 64'(req_ready), 64'(0));
    rd('h105, D_105, 1'b0, LAT + 2);
    drain();

    // Reset in the middle of a write's BUSY phase with three reads queued behind it.
    wr('h40, D_40Y);
    drain();
    issue(1'b1, 'h40, D_40Z);
    issue(1'b0, 'h40, '0);
    issue(1'b0, 'h40, '0);
    issue(1'b0, 'h40, '0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'(1));
    chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
    @(negedge clk) reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_req_ready", 64'(req_ready), 64'(1));
    rd('h40, D_40Y, 1'b1, 0);
    drain();

    // Write acknowledge presence depends on the build.
    n0 = n_resp;
    wr('h50, D_50);
    drain();
`ifdef CPU_MEM_WRITE_ACK_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    chk("write_ack_count", 64'(n_resp - n0), 64'(exp_n));
    rd('h50, D_50, 1'b1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
